// File: rtl/blackjack_pkg.sv
// Shared types and hand arithmetic for the blackjack game controller.
package blackjack_pkg;

  localparam int unsigned HAND_W    = 5;
  localparam int unsigned RANK_W    = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned BLACKJACK = 21;

  typedef enum logic [2:0] {
    BET         = 3'd0,
    DEAL        = 3'd1,
    SHOW_DEALER = 3'd2,
    PLAYER      = 3'd3,
    REVEAL      = 3'd4,
    DEALER_DRAW = 3'd5,
    RESULT      = 3'd6
  } phase_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_WIN  = 2'd1,
    RES_LOSE = 2'd2,
    RES_DRAW = 2'd3
  } result_e;

  // Face cards count as 10; an ace counts as 1 here and is promoted in best_total.
  function automatic logic [HAND_W-1:0] card_value(input logic [RANK_W-1:0] rank);
    return (rank > RANK_W'(10)) ? HAND_W'(10) : HAND_W'(rank);
  endfunction

  function automatic logic [HAND_W-1:0] best_total(input logic [HAND_W-1:0] hard,
                                                   input logic              has_ace);
    return (has_ace && hard <= HAND_W'(BLACKJACK - 10)) ? hard + HAND_W'(10) : hard;
  endfunction

endpackage

// File: rtl/hand_accum.sv
// One blackjack hand: hard sum, ace flag, card count and registered best/bust.
module hand_accum
  import blackjack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [RANK_W-1:0] rank,
  output logic [HAND_W-1:0] hard,
  output logic              has_ace,
  output logic [HAND_W-1:0] best,
  output logic              bust,
  output logic [CNT_W-1:0]  count
);

  logic [HAND_W-1:0] hard_q, hard_d, best_q, best_d;
  logic              ace_q, ace_d, bust_q, bust_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    hard_d  = hard_q;
    ace_d   = ace_q;
    count_d = count_q;
    if (clear) begin
      hard_d  = '0;
      ace_d   = 1'b0;
      count_d = '0;
    end else if (add) begin
      hard_d  = hard_q + card_value(rank);
      ace_d   = ace_q | (rank == RANK_W'(1));
      count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    end
    // best/bust are registered from the next-state sum so they land with the card.
    best_d = best_total(hard_d, ace_d);
    bust_d = best_d > HAND_W'(BLACKJACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hard_q  <= '0;
      ace_q   <= 1'b0;
      count_q <= '0;
      best_q  <= '0;
      bust_q  <= 1'b0;
    end else begin
      hard_q  <= hard_d;
      ace_q   <= ace_d;
      count_q <= count_d;
      best_q  <= best_d;
      bust_q  <= bust_d;
    end
  end

  assign hard    = hard_q;
  assign has_ace = ace_q;
  assign best    = best_q;
  assign bust    = bust_q;
  assign count   = count_q;

endmodule

// File: rtl/blackjack_game_ctrl.sv
// Blackjack round sequencer: bet, deal, player/dealer turns, payout.
// Optional double-down in PLAYER is enabled by defining DOUBLE_DOWN_EN.
module blackjack_game_ctrl
  import blackjack_pkg::*;
#(
  parameter int unsigned       COIN_W       = 8,
  parameter logic [COIN_W-1:0] START_COINS  = COIN_W'(20),
  parameter int unsigned       DEALER_STAND = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              next,
  input  logic              hit,
  input  logic              stand,
  input  logic              double,
  input  logic              bet_8,
  input  logic              bet_4,
  input  logic              bet_2,
  input  logic              bet_1,
  output logic              card_req,
  input  logic              card_ack,
  input  logic [RANK_W-1:0] card_rank,
  output logic [2:0]        phase,
  output logic [HAND_W-1:0] player_total,
  output logic [HAND_W-1:0] dealer_total,
  output logic [COIN_W-1:0] coins,
  output logic              LED_Win,
  output logic              LED_Lose,
  output logic              LED_Draw
);

  phase_e            state_q, state_d;
  logic [3:0]        btn_c, btn_q, prev_q, edge_c;
  logic              pend_q, pend_d, eval_q, eval_d, tgt_q, tgt_d, dbl_q, dbl_d;
  logic [1:0]        deal_idx_q, deal_idx_d;
  logic [COIN_W-1:0] bet_q, bet_d, coins_q, coins_d;
  logic [HAND_W-1:0] upcard_q, upcard_d, dtot_q, dtot_d;
  logic              req_q, req_d, win_q, win_d, lose_q, lose_d, draw_q, draw_d;
  logic              ack_acc, busy_c, go_next, go_hit, go_stand, go_dbl, clear_c;
  logic [3:0]        bet_c;
  logic [COIN_W+1:0] credit_c, sum_c;
  result_e           res_c;

  logic [HAND_W-1:0] p_hard, p_best, d_hard, d_best;
  logic              p_ace, p_bust, d_ace, d_bust;
  logic [CNT_W-1:0]  p_cnt, d_cnt;
  logic              unused_c;

`ifdef DOUBLE_DOWN_EN
  assign btn_c    = {double, stand, hit, next};
  assign unused_c = ^{p_hard, p_ace, d_hard, d_ace, d_cnt};
`else
  assign btn_c    = {1'b0, stand, hit, next};
  assign unused_c = ^{p_hard, p_ace, d_hard, d_ace, d_cnt, p_cnt, double, go_dbl};
`endif

  assign bet_c    = {bet_8, bet_4, bet_2, bet_1};
  assign edge_c   = btn_q & ~prev_q;
  assign ack_acc  = card_ack & pend_q;
  assign busy_c   = pend_q | eval_q;
  assign go_next  = edge_c[0] & ~busy_c;
  assign go_hit   = edge_c[1] & ~busy_c;
  assign go_stand = edge_c[2] & ~busy_c;
  assign go_dbl   = edge_c[3] & ~busy_c;

  hand_accum u_player (
    .clk(clk), .reset(reset), .clear(clear_c), .add(ack_acc & ~tgt_q), .rank(card_rank),
    .hard(p_hard), .has_ace(p_ace), .best(p_best), .bust(p_bust), .count(p_cnt)
  );

  hand_accum u_dealer (
    .clk(clk), .reset(reset), .clear(clear_c), .add(ack_acc & tgt_q), .rank(card_rank),
    .hard(d_hard), .has_ace(d_ace), .best(d_best), .bust(d_bust), .count(d_cnt)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q & ~ack_acc;
    eval_d     = ack_acc;
    tgt_d      = tgt_q;
    dbl_d      = dbl_q;
    deal_idx_d = deal_idx_q;
    bet_d      = bet_q;
    coins_d    = coins_q;
    upcard_d   = upcard_q;
    req_d      = 1'b0;
    win_d      = win_q;
    lose_d     = lose_q;
    draw_d     = draw_q;
    clear_c    = 1'b0;
    res_c      = RES_NONE;
    credit_c   = '0;
    sum_c      = '0;

    case (state_q)
      BET: begin
        if (go_next && bet_c != 4'd0 && COIN_W'(bet_c) <= coins_q) begin
          coins_d    = coins_q - COIN_W'(bet_c);
          bet_d      = COIN_W'(bet_c);
          deal_idx_d = 2'd0;
          clear_c    = 1'b1;
          state_d    = DEAL;
        end
      end
      DEAL: begin
        // Even deal slots go to the player, odd slots to the dealer.
        if (ack_acc) begin
          deal_idx_d = deal_idx_q + 2'd1;
          if (deal_idx_q == 2'd1) upcard_d = card_value(card_rank);
          if (deal_idx_q == 2'd3) state_d = SHOW_DEALER;
        end else if (!busy_c) begin
          req_d  = 1'b1;
          pend_d = 1'b1;
          tgt_d  = deal_idx_q[0];
        end
      end
      SHOW_DEALER: if (go_next) state_d = PLAYER;
      PLAYER: begin
        if (eval_q) begin
          dbl_d = 1'b0;
          if (p_bust)     state_d = RESULT;
          else if (dbl_q) state_d = REVEAL;
        end else if (go_stand) begin
          state_d = REVEAL;
`ifdef DOUBLE_DOWN_EN
        end else if (go_dbl && p_cnt == CNT_W'(2) && coins_q >= bet_q) begin
          coins_d = coins_q - bet_q;
          bet_d   = bet_q << 1;
          dbl_d   = 1'b1;
          req_d   = 1'b1;
          pend_d  = 1'b1;
          tgt_d   = 1'b0;
`endif
        end else if (go_hit) begin
          req_d  = 1'b1;
          pend_d = 1'b1;
          tgt_d  = 1'b0;
        end
      end
      REVEAL: if (go_next) state_d = DEALER_DRAW;
      DEALER_DRAW: begin
        if (!busy_c) begin
          if (d_best < HAND_W'(DEALER_STAND)) begin
            req_d  = 1'b1;
            pend_d = 1'b1;
            tgt_d  = 1'b1;
          end else begin
            state_d = RESULT;
          end
        end
      end
      RESULT: begin
        // First RESULT cycle settles the outcome; afterwards wait for next.
        if (!(win_q | lose_q | draw_q)) begin
          if (p_bust)                        res_c = RES_LOSE;
          else if (d_bust || p_best > d_best) res_c = RES_WIN;
          else if (p_best == d_best)         res_c = RES_DRAW;
          else                               res_c = RES_LOSE;
          win_d  = (res_c == RES_WIN);
          lose_d = (res_c == RES_LOSE);
          draw_d = (res_c == RES_DRAW);
          if (res_c == RES_WIN)       credit_c = {1'b0, bet_q, 1'b0};
          else if (res_c == RES_DRAW) credit_c = {2'b00, bet_q};
          sum_c   = (COIN_W+2)'(coins_q) + credit_c;
          coins_d = (sum_c > (COIN_W+2)'({COIN_W{1'b1}})) ? '1 : COIN_W'(sum_c);
        end else if (go_next) begin
          win_d    = 1'b0;
          lose_d   = 1'b0;
          draw_d   = 1'b0;
          bet_d    = '0;
          upcard_d = '0;
          clear_c  = 1'b1;
          state_d  = BET;
        end
      end
      default: state_d = BET;
    endcase

    dtot_d = (state_q inside {REVEAL, DEALER_DRAW, RESULT}) ? d_best : upcard_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BET;
      btn_q      <= '0;
      prev_q     <= '0;
      pend_q     <= 1'b0;
      eval_q     <= 1'b0;
      tgt_q      <= 1'b0;
      dbl_q      <= 1'b0;
      deal_idx_q <= '0;
      bet_q      <= '0;
      coins_q    <= START_COINS;
      upcard_q   <= '0;
      dtot_q     <= '0;
      req_q      <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      draw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_c;
      prev_q     <= btn_q;
      pend_q     <= pend_d;
      eval_q     <= eval_d;
      tgt_q      <= tgt_d;
      dbl_q      <= dbl_d;
      deal_idx_q <= deal_idx_d;
      bet_q      <= bet_d;
      coins_q    <= coins_d;
      upcard_q   <= upcard_d;
      dtot_q     <= dtot_d;
      req_q      <= req_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      draw_q     <= draw_d;
    end
  end

  assign card_req     = req_q;
  assign phase        = state_q;
  assign player_total = p_best;
  assign dealer_total = dtot_q;
  assign coins        = coins_q;
  assign LED_Win      = win_q;
  assign LED_Lose     = lose_q;
  assign LED_Draw     = draw_q;

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Directed bench for blackjack_game_ctrl with a queued deck responder.
module tb_blackjack_game_ctrl;

  localparam logic [2:0] P_BET = 3'd0, P_SHOW = 3'd2, P_PLAYER = 3'd3,
                         P_REVEAL = 3'd4, P_DDRAW = 3'd5, P_RESULT = 3'd6;

  logic       clk = 1'b0;
  logic       reset, next, hit, stand, dbl, bet_8, bet_4, bet_2, bet_1;
  logic       card_req, card_ack;
  logic [3:0] card_rank;
  logic [2:0] phase;
  logic [4:0] player_total, dealer_total;
  logic [7:0] coins;
  logic       LED_Win, LED_Lose, LED_Draw;

  int unsigned n_chk = 0, n_pass = 0;
  int unsigned req_cnt = 0, underflow = 0, rd_ptr = 0, wr_ptr = 0, r0;
  int          ack_dly = 1;
  logic [3:0]  deck_mem [0:63];

  always #5 clk = ~clk;

  blackjack_game_ctrl dut (
    .clk(clk), .reset(reset), .next(next), .hit(hit), .stand(stand), .double(dbl),
    .bet_8(bet_8), .bet_4(bet_4), .bet_2(bet_2), .bet_1(bet_1),
    .card_req(card_req), .card_ack(card_ack), .card_rank(card_rank),
    .phase(phase), .player_total(player_total), .dealer_total(dealer_total),
    .coins(coins), .LED_Win(LED_Win), .LED_Lose(LED_Lose), .LED_Draw(LED_Draw)
  );

  always @(negedge clk) if (card_req === 1'b1) req_cnt++;

  // Deck: answers each request after ack_dly cycles with the next queued rank.
  initial begin
    card_ack  = 1'b0;
    card_rank = 4'd0;
    forever begin
      @(negedge clk);
      if (card_req === 1'b1) begin
        repeat (ack_dly - 1) @(negedge clk);
        if (rd_ptr != wr_ptr) begin
          card_rank = deck_mem[rd_ptr[5:0]];
          rd_ptr++;
        end else begin
          card_rank = 4'd2;
          underflow++;
        end
        card_ack = 1'b1;
        @(negedge clk);
        card_ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [3:0] r);
    deck_mem[wr_ptr[5:0]] = r;
    wr_ptr++;
  endtask

  task automatic load4(input logic [3:0] a, b, c, d);
    load(a); load(b); load(c); load(d);
  endtask

  task automatic set_bet(input logic [3:0] v);
    {bet_8, bet_4, bet_2, bet_1} = v;
  endtask

  task automatic press(input logic n, h, s, d);
    @(negedge clk);
    next = n; hit = h; stand = s; dbl = d;
    tick(2);
    next = 0; hit = 0; stand = 0; dbl = 0;
    tick(1);
  endtask

  task automatic wait_phase(input string tag, input logic [2:0] exp);
    int n = 0;
    while (phase !== exp && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(phase), 32'(exp));
    tick(2);
  endtask

  task automatic deal_round(input string tag, input logic [3:0] bet, input int c_after,
                            input int up, input int ptot);
    set_bet(bet);
    press(1, 0, 0, 0);
    wait_phase({tag, " show"}, P_SHOW);
    check({tag, " coins after bet"}, 32'(coins), 32'(c_after));
    check({tag, " upcard"}, 32'(dealer_total), 32'(up));
    press(1, 0, 0, 0);
    wait_phase({tag, " player"}, P_PLAYER);
    check({tag, " player total"}, 32'(player_total), 32'(ptot));
  endtask

  task automatic result_check(input string tag, input logic [2:0] leds, input int c, input int dt);
    wait_phase({tag, " result"}, P_RESULT);
    check({tag, " leds"}, 32'({LED_Win, LED_Lose, LED_Draw}), 32'(leds));
    check({tag, " coins"}, 32'(coins), 32'(c));
    check({tag, " dealer total"}, 32'(dealer_total), 32'(dt));
  endtask

  task automatic exit_round(input string tag);
    press(1, 0, 0, 0);
    wait_phase({tag, " back to bet"}, P_BET);
    check({tag, " cleared"}, 32'({LED_Win, LED_Lose, LED_Draw, player_total, dealer_total}), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    next = 0; hit = 0; stand = 0; dbl = 0;
    set_bet(4'd0);
    tick(3);
    check("reset phase", 32'(phase), 32'(P_BET));
    check("reset coins", 32'(coins), 32'd20);
    check("reset outputs", 32'({card_req, LED_Win, LED_Lose, LED_Draw, player_total, dealer_total}), 32'd0);
    reset = 1'b1;
    tick(2);

    // A: 17 vs dealer 14 + 3 = 17, push returns the bet.
    load4(4'd10, 4'd5, 4'd7, 4'd9);
    deal_round("A", 4'd6, 14, 5, 17);
    press(0, 0, 1, 0);
    wait_phase("A reveal", P_REVEAL);
    check("A revealed total", 32'(dealer_total), 32'd14);
    load(4'd3);
    press(1, 0, 0, 0);
    result_check("A", 3'b001, 20, 17);
    exit_round("A");

    // B: soft 20, hit 5 drops ace to 1 (hard 15), loses to 17.
    load4(4'd1, 4'd10, 4'd9, 4'd7);
    deal_round("B", 4'd2, 18, 10, 20);
    load(4'd5);
    press(0, 1, 0, 0);
    tick(ack_dly + 8);
    check("B phase after hit", 32'(phase), 32'(P_PLAYER));
    check("B hard total", 32'(player_total), 32'd15);
    press(0, 0, 1, 0);
    wait_phase("B reveal", P_REVEAL);
    press(1, 0, 0, 0);
    result_check("B", 3'b010, 18, 17);
    exit_round("B");

    // C: player busts, dealer never draws.
    r0 = req_cnt;
    load4(4'd10, 4'd10, 4'd6, 4'd7);
    deal_round("C", 4'd3, 15, 10, 16);
    load(4'd12);
    press(0, 1, 0, 0);
    result_check("C", 3'b010, 15, 17);
    check("C requests", req_cnt - r0, 32'd5);
    check("C deck consumed", rd_ptr, wr_ptr);
    exit_round("C");

    // D: 18 vs dealer 16 + 5 = 21.
    load4(4'd10, 4'd10, 4'd8, 4'd6);
    deal_round("D", 4'd5, 10, 10, 18);
    press(0, 0, 1, 0);
    wait_phase("D reveal", P_REVEAL);
    check("D revealed total", 32'(dealer_total), 32'd16);
    load(4'd5);
    press(1, 0, 0, 0);
    result_check("D", 3'b010, 10, 21);
    exit_round("D");

    // Invalid bets: zero and more than the balance.
    r0 = req_cnt;
    set_bet(4'd0);
    press(1, 0, 0, 0);
    tick(4);
    check("bet0 phase", 32'(phase), 32'(P_BET));
    set_bet(4'd11);
    press(1, 0, 0, 0);
    tick(4);
    check("bet>coins phase", 32'(phase), 32'(P_BET));
    check("bad bet coins", 32'(coins), 32'd10);
    check("bad bet no request", req_cnt - r0, 32'd0);

    // E: hit+stand together -> stand; dealer 16 + 10 busts.
    load4(4'd10, 4'd10, 4'd8, 4'd6);
    deal_round("E", 4'd5, 5, 10, 18);
    r0 = req_cnt;
    press(0, 1, 1, 0);
    wait_phase("E stand priority", P_REVEAL);
    check("E no hit card", req_cnt - r0, 32'd0);
    check("E player total", 32'(player_total), 32'd18);
    load(4'd10);
    press(1, 0, 0, 0);
    result_check("E", 3'b100, 15, 26);
    exit_round("E");

    // G: slow deck; 9 vs dealer 18, one more card 9 -> push.
    ack_dly = 7;
    r0 = req_cnt;
    load4(4'd5, 4'd10, 4'd4, 4'd8);
    load(4'd9);
    deal_round("G", 4'd4, 11, 10, 9);
`ifdef DOUBLE_DOWN_EN
    press(0, 0, 0, 1);
    wait_phase("G double reveal", P_REVEAL);
    check("G coins after double", 32'(coins), 32'd7);
    check("G player total", 32'(player_total), 32'd18);
`else
    press(0, 0, 0, 1);
    tick(20);
    check("G double ignored phase", 32'(phase), 32'(P_PLAYER));
    check("G double ignored coins", 32'(coins), 32'd11);
    check("G double no request", req_cnt - r0, 32'd4);
    press(0, 1, 0, 0);
    tick(ack_dly + 8);
    check("G player total", 32'(player_total), 32'd18);
    press(0, 0, 1, 0);
    wait_phase("G reveal", P_REVEAL);
`endif
    check("G one request per card", req_cnt - r0, 32'd5);
    press(1, 0, 0, 0);
    result_check("G", 3'b001, 15, 18);
    exit_round("G");

    // H: reset while the dealer's card request is in flight.
    load4(4'd10, 4'd2, 4'd10, 4'd3);
    deal_round("H", 4'd3, 12, 2, 20);
    press(0, 0, 1, 0);
    wait_phase("H reveal", P_REVEAL);
    load(4'd10);
    r0 = req_cnt;
    press(1, 0, 0, 0);
    wait_phase("H dealer draw", P_DDRAW);
    tick(1);
    check("H request outstanding", req_cnt - r0, 32'd1);
    reset = 1'b0;
    tick(2);
    check("H reset phase", 32'(phase), 32'(P_BET));
    check("H reset coins", 32'(coins), 32'd20);
    reset = 1'b1;
    tick(15);
    check("H late ack ignored", 32'({phase, player_total, dealer_total}), 32'd0);
    check("H coins after late ack", 32'(coins), 32'd20);
    check("deck underflow", underflow, 32'd0);
    check("deck fully used", rd_ptr, wr_ptr);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
